// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants, state encoding and request-attribute record for the
// two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = 4;
    localparam int CNT_W   = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic [BE_W-1:0]   be;
    } req_attr_t;

    function automatic logic [NUM_REQ-1:0] owner_mask(input logic idx);
        logic [NUM_REQ-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and cache-side signals of the memory port arbiter.
// The arbiter uses the slave view; the environment drives the master view.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*ADDR_W-1:0] addr_i;
    logic [NUM_REQ*DATA_W-1:0] wdata_i;
    logic [NUM_REQ-1:0]        we_i;
    logic [NUM_REQ*BE_W-1:0]   be_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        rvalid_o;
    logic [NUM_REQ-1:0]        err_o;
    logic [DATA_W-1:0]         rdata_o;

    logic                      mem_req_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [DATA_W-1:0]         mem_wdata_o;
    logic                      mem_we_o;
    logic [BE_W-1:0]           mem_be_o;
    logic                      mem_gnt_i;
    logic                      mem_rvalid_i;
    logic [DATA_W-1:0]         mem_rdata_i;

    modport slave (
        input  req_i, addr_i, wdata_i, we_i, be_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o,
        output mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o
    );

    modport master (
        output req_i, addr_i, wdata_i, we_i, be_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o,
        input  mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational winner select: round-robin against the last owner, or
// strict priority to requester 0 when FIXED_PRIO is set.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_owner,
    output logic               valid,
    output logic               winner
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (FIXED_PRIO != 0) begin
            winner = !req[0];
        end else if (&req) begin
            // Tie: whoever was not served last goes next.
            winner = !last_owner;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: one downstream transaction at a time,
// registered request attributes, and a WAIT timeout that answers with error.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic            clk,
    input logic            reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]       state;
    logic             owner;
    logic             last_owner;
    logic [CNT_W-1:0] wait_cnt;
    req_attr_t        attr;

    logic             pick_valid;
    logic             pick_winner;
    req_attr_t        pick_attr;
    logic             in_req;
    logic             in_wait;
    logic             timeout;

    rr_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req        (bus.req_i),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        pick_attr.addr  = pick_winner ? bus.addr_i[63:32]  : bus.addr_i[31:0];
        pick_attr.wdata = pick_winner ? bus.wdata_i[63:32] : bus.wdata_i[31:0];
        pick_attr.we    = pick_winner ? bus.we_i[1]        : bus.we_i[0];
        pick_attr.be    = pick_winner ? bus.be_i[7:4]      : bus.be_i[3:0];
    end

    assign in_req  = (state == REQ);
    assign in_wait = (state == WAIT);
    // A response arriving on the timeout cycle is treated as late and dropped.
    assign timeout = in_wait && (wait_cnt == TIMEOUT_VAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            wait_cnt   <= '0;
            attr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_winner;
                        attr  <= pick_attr;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_gnt_i) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (timeout || bus.mem_rvalid_i) begin
                        last_owner <= owner;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_req_o   = in_req;
        bus.mem_addr_o  = attr.addr;
        bus.mem_wdata_o = attr.wdata;
        bus.mem_we_o    = attr.we;
        bus.mem_be_o    = attr.be;

        bus.gnt_o    = '0;
        bus.rvalid_o = '0;
        bus.err_o    = '0;
        bus.rdata_o  = '0;

        if (in_req && bus.mem_gnt_i) begin
            bus.gnt_o = owner_mask(owner);
        end
        if (timeout) begin
            bus.rvalid_o = owner_mask(owner);
            bus.err_o    = owner_mask(owner);
        end else if (in_wait) begin
            bus.rdata_o = bus.mem_rdata_i;
            if (bus.mem_rvalid_i) begin
                bus.rvalid_o = owner_mask(owner);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin/timeout instance plus a
// fixed-priority instance sharing the same stimulus.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    logic [1:0]  req;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  we;
    logic [7:0]  be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    mem_port_arbiter_if bus_rr ();
    mem_port_arbiter_if bus_fp ();

    assign bus_rr.req_i = req;         assign bus_fp.req_i = req;
    assign bus_rr.addr_i = addr;       assign bus_fp.addr_i = addr;
    assign bus_rr.wdata_i = wdata;     assign bus_fp.wdata_i = wdata;
    assign bus_rr.we_i = we;           assign bus_fp.we_i = we;
    assign bus_rr.be_i = be;           assign bus_fp.be_i = be;
    assign bus_rr.mem_gnt_i = mem_gnt;       assign bus_fp.mem_gnt_i = mem_gnt;
    assign bus_rr.mem_rvalid_i = mem_rvalid; assign bus_fp.mem_rvalid_i = mem_rvalid;
    assign bus_rr.mem_rdata_i = mem_rdata;   assign bus_fp.mem_rdata_i = mem_rdata;

    mem_port_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(4)) u_rr (
        .clk (clk), .reset (reset), .bus (bus_rr)
    );
    mem_port_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(255)) u_fp (
        .clk (clk), .reset (reset), .bus (bus_fp)
    );

    // Observation mux: sel=0 watches the round-robin DUT, sel=1 the fixed one.
    bit          sel = 0;
    logic [1:0]  m_gnt, m_rvalid, m_err;
    logic [31:0] m_rdata, m_addr, m_wdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;

    always_comb begin
        m_gnt    = sel ? bus_fp.gnt_o       : bus_rr.gnt_o;
        m_rvalid = sel ? bus_fp.rvalid_o    : bus_rr.rvalid_o;
        m_err    = sel ? bus_fp.err_o       : bus_rr.err_o;
        m_rdata  = sel ? bus_fp.rdata_o     : bus_rr.rdata_o;
        m_req    = sel ? bus_fp.mem_req_o   : bus_rr.mem_req_o;
        m_addr   = sel ? bus_fp.mem_addr_o  : bus_rr.mem_addr_o;
        m_wdata  = sel ? bus_fp.mem_wdata_o : bus_rr.mem_wdata_o;
        m_we     = sel ? bus_fp.mem_we_o    : bus_rr.mem_we_o;
        m_be     = sel ? bus_fp.mem_be_o    : bus_rr.mem_be_o;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit arm_fp = 0;
    int gnt1_seen = 0;
    always @(negedge clk) begin
        if (arm_fp && bus_fp.gnt_o[1]) gnt1_seen = gnt1_seen + 1;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, 64'(m_req), 64'd0);
        check({tag, "_gnt"}, 64'(m_gnt), 64'd0);
        check({tag, "_rvalid"}, 64'(m_rvalid), 64'd0);
        check({tag, "_err"}, 64'(m_err), 64'd0);
        check({tag, "_rdata"}, 64'(m_rdata), 64'd0);
        check({tag, "_mem_addr"}, 64'(m_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(m_wdata), 64'd0);
        check({tag, "_mem_we"}, 64'(m_we), 64'd0);
        check({tag, "_mem_be"}, 64'(m_be), 64'd0);
    endtask

    // Starts in the IDLE cycle with req already applied; returns in the
    // IDLE cycle that follows the response.
    task automatic do_txn(input string name, input int owner, input logic [31:0] ea,
                          input logic [31:0] ewd, input logic ewe, input logic [3:0] ebe,
                          input int gnt_delay, input int rv_delay,
                          input logic [31:0] rd, input bit drop_req);
        logic [1:0] mask;
        bit ok;
        mask = 2'(1 << owner);
        @(posedge clk); #1;
        if (drop_req) req = 2'b00;
        check({name, "_mem_req"}, 64'(m_req), 64'd1);
        check({name, "_mem_addr"}, 64'(m_addr), 64'(ea));
        check({name, "_mem_wdata"}, 64'(m_wdata), 64'(ewd));
        check({name, "_mem_we"}, 64'(m_we), 64'(ewe));
        check({name, "_mem_be"}, 64'(m_be), 64'(ebe));
        ok = 1;
        for (int i = 0; i < gnt_delay; i++) begin
            @(negedge clk);
            if (m_gnt !== 2'b00 || m_req !== 1'b1 || m_addr !== ea || m_wdata !== ewd ||
                m_we !== ewe || m_be !== ebe) ok = 0;
            @(posedge clk); #1;
        end
        if (gnt_delay > 0) check({name, "_hold_stable"}, 64'(ok), 64'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        check({name, "_gnt"}, 64'(m_gnt), 64'(mask));
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        ok = 1;
        for (int i = 0; i < rv_delay; i++) begin
            @(negedge clk);
            if (m_rvalid !== 2'b00) ok = 0;
            @(posedge clk); #1;
        end
        check({name, "_wait_quiet"}, 64'(ok), 64'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        @(negedge clk);
        check({name, "_rvalid"}, 64'(m_rvalid), 64'(mask));
        check({name, "_err"}, 64'(m_err), 64'd0);
        check({name, "_rdata"}, 64'(m_rdata), 64'(rd));
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  we;
        logic [7:0]  be;
        int          owner;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{2'b11, 64'h2000_0000_1000_0000, 64'hB1B1_B1B1_A0A0_A0A0, 2'b00, 8'hFF,
                  0, 32'h1000_0000, 32'hA0A0_A0A0, 1'b0, 4'hF, 32'h1111_0000};
        vt[1] = '{2'b11, 64'h2000_0000_1000_0000, 64'hB1B1_B1B1_A0A0_A0A0, 2'b00, 8'hFF,
                  1, 32'h2000_0000, 32'hB1B1_B1B1, 1'b0, 4'hF, 32'h2222_0001};
        vt[2] = '{2'b11, 64'h2000_0010_1000_0010, 64'h0000_0000_0000_0000, 2'b00, 8'h5A,
                  0, 32'h1000_0010, 32'h0000_0000, 1'b0, 4'hA, 32'h3333_0002};
        vt[3] = '{2'b01, 64'h2000_0020_1000_0040, 64'h0000_0000_0000_0000, 2'b00, 8'hFF,
                  0, 32'h1000_0040, 32'h0000_0000, 1'b0, 4'hF, 32'h4444_0003};
        vt[4] = '{2'b10, 64'h0000_0104_1000_0050, 64'hDEAD_BEEF_0BAD_F00D, 2'b10, 8'h3F,
                  1, 32'h0000_0104, 32'hDEAD_BEEF, 1'b1, 4'b0011, 32'h0000_0000};
        vt[5] = '{2'b10, 64'h0000_0200_1000_0060, 64'h0000_0000_0000_0000, 2'b00, 8'hC0,
                  1, 32'h0000_0200, 32'h0000_0000, 1'b0, 4'hC, 32'h5555_0005};
        vt[6] = '{2'b11, 64'h0000_0300_1000_0070, 64'h0000_0000_0000_0000, 2'b01, 8'h91,
                  0, 32'h1000_0070, 32'h0000_0000, 1'b1, 4'h1, 32'h6666_0006};

        reset = 1'b1;
        req = 2'b11; addr = 64'hFFFF_FFFF_FFFF_FFFF; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        we = 2'b11; be = 8'hFF; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        req = 2'b00; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Alternation, single requests, write path.
        for (int i = 0; i < 7; i++) begin
            req = vt[i].req; addr = vt[i].addr; wdata = vt[i].wdata;
            we = vt[i].we; be = vt[i].be;
            do_txn($sformatf("vec%0d", i), vt[i].owner, vt[i].e_addr, vt[i].e_wdata,
                   vt[i].e_we, vt[i].e_be, 0, 1, vt[i].rdata, 0);
        end

        // Downstream grant stalled for 10 cycles.
        req = 2'b01; addr = 64'h0000_0000_4000_0004; wdata = 64'h0000_0000_CAFE_0001;
        we = 2'b01; be = 8'h0F;
        do_txn("stall", 0, 32'h4000_0004, 32'hCAFE_0001, 1'b1, 4'hF, 10, 2, 32'h7777_0007, 0);

        // Requester drops its request after latching; transaction still completes.
        req = 2'b10; addr = 64'h5000_0008_0000_0000; wdata = 64'd0; we = 2'b00; be = 8'hF0;
        do_txn("drop", 1, 32'h5000_0008, 32'h0, 1'b0, 4'hF, 2, 0, 32'h8888_0008, 1);
        @(negedge clk);
        check("drop_idle_mem_req", 64'(m_req), 64'd0);
        @(posedge clk); #1;

        // Timeout: no response for 4 WAIT cycles, then late response in IDLE.
        req = 2'b01; addr = 64'h0000_0000_6000_0000; wdata = 64'd0; we = 2'b00; be = 8'h0F;
        @(posedge clk); #1;
        req = 2'b00;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        begin
            bit ok = 1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (m_rvalid !== 2'b00 || m_err !== 2'b00) ok = 0;
                @(posedge clk); #1;
            end
            check("to_quiet", 64'(ok), 64'd1);
        end
        @(negedge clk);
        check("to_rvalid", 64'(m_rvalid), 64'd1);
        check("to_err", 64'(m_err), 64'd1);
        check("to_rdata", 64'(m_rdata), 64'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b1;
        @(negedge clk);
        check("late_rvalid", 64'(m_rvalid), 64'd0);
        check("late_err", 64'(m_err), 64'd0);
        check("late_rdata", 64'(m_rdata), 64'd0);
        check("late_mem_req", 64'(m_req), 64'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        // Timeout updated last_owner to 0, so the tie goes to requester 1.
        req = 2'b11; addr = 64'h7000_0000_6000_0000; be = 8'hFF;
        do_txn("post_to", 1, 32'h7000_0000, 32'h0, 1'b0, 4'hF, 0, 1, 32'h9999_0009, 0);

        // Reset during WAIT with a response being presented.
        req = 2'b10; addr = 64'h8000_0000_0000_0000; wdata = 64'h1234_5678_0000_0000;
        we = 2'b10; be = 8'hF0;
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        check("pre_rst_rvalid", 64'(m_rvalid), 64'd2);
        reset = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        reset = 1'b0;
        req = 2'b11; addr = 64'h9000_0000_9000_0004; wdata = 64'd0; we = 2'b00; be = 8'hFF;
        do_txn("post_rst", 0, 32'h9000_0004, 32'h0, 1'b0, 4'hF, 0, 1, 32'hAAAA_000A, 0);

        // Fixed priority: requester 0 wins every time while both request.
        sel = 1;
        reset = 1'b1; req = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        arm_fp = 1;
        req = 2'b11; addr = 64'hB000_0000_A000_0000; wdata = 64'd0; we = 2'b00; be = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            do_txn($sformatf("fp%0d", i), 0, 32'hA000_0000, 32'h0, 1'b0, 4'hF, 0, 1,
                   32'h0F0F_0000 + 32'(i), 0);
        end
        arm_fp = 0;
        check("fp_gnt1_never", 64'(gnt1_seen), 64'd0);
        req = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
